// File: rtl/uart_rx_param_if.sv
// Serial-in and parallel-out bundle of the uart_rx_param receiver.
// The line/config driver uses master. The receiver uses slave.
interface uart_rx_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STP_2;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, STP_2,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, STP_2,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// 1 or 2 stop bits, optional parity, and per-frame error pulses.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s = 0 (start edge 0)
// START  | timing the start bit; a majority of 1 is a glitch
// DATA   | receiving DATA_WIDTH bits, LSB first
// PARITY | receiving the parity bit
// STOP1  | first stop bit
// STOP2  | second stop bit (only when STP_2 was latched)
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_param_if.slave bus
);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  rx_meta;
    logic                  rx_s;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] p_lat;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] presc_clamped;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic                  stp2_l;
    logic                  smp0;
    logic                  smp1;
    logic                  smp2;
    logic                  smp2_eff;
    logic                  maj;
    logic                  par_flag;
    logic                  stp_flag;
    logic                  stp_bad;
    logic                  bit_end;
    logic                  start_det;
    logic                  eof;
    logic                  dv_q;
    logic                  pe_q;
    logic                  se_q;

    assign presc_clamped = (bus.Prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : bus.Prescale;
    assign half          = p_lat >> 1;
    assign bit_end       = (edge_cnt == p_lat - PRESCALE_W'(1));

    // At P=4 the third sample point coincides with the decision edge,
    // so the live synchronised value stands in for the not-yet-stored sample.
    assign smp2_eff = (edge_cnt == half + PRESCALE_W'(1)) ? rx_s : smp2;
    assign maj      = (smp0 & smp1) | (smp0 & smp2_eff) | (smp1 & smp2_eff);

    assign stp_bad = stp_flag | (((state == STOP1) || (state == STOP2)) & ~maj);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        eof       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == BIT_W'(DATA_WIDTH - 1))) begin
                    state_nxt = par_en_l ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP1;
                end
            end
            STOP1: begin
                if (bit_end) begin
                    if (stp2_l) begin
                        state_nxt = STOP2;
                    end else begin
                        state_nxt = IDLE;
                        eof       = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    eof       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            p_lat     <= PRESCALE_W'(4);
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            stp2_l    <= 1'b0;
            smp0      <= 1'b1;
            smp1      <= 1'b1;
            smp2      <= 1'b1;
            shift_q   <= '0;
            par_flag  <= 1'b0;
            stp_flag  <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;

            // The IDLE cycle that sees the start edge counts as edge 0.
            if (state == IDLE) begin
                edge_cnt <= start_det ? PRESCALE_W'(1) : '0;
            end else if (bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end

            if (start_det) begin
                p_lat     <= presc_clamped;
                par_en_l  <= bus.PAR_EN;
                par_typ_l <= bus.PAR_TYP;
                stp2_l    <= bus.STP_2;
                par_flag  <= 1'b0;
                stp_flag  <= 1'b0;
            end

            if (state != IDLE) begin
                if (edge_cnt == half - PRESCALE_W'(1)) smp0 <= rx_s;
                if (edge_cnt == half)                  smp1 <= rx_s;
                if (edge_cnt == half + PRESCALE_W'(1)) smp2 <= rx_s;
            end

            if (bit_end) begin
                case (state)
                    START: bit_cnt <= '0;
                    DATA: begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
                    end
                    PARITY: par_flag <= (maj != ((^shift_q) ^ par_typ_l));
                    STOP1, STOP2: begin
                        if (!maj) stp_flag <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (eof) begin
                dv_q     <= ~par_flag & ~stp_bad;
                pe_q     <= par_flag;
                se_q     <= stp_bad;
                par_flag <= 1'b0;
                stp_flag <= 1'b0;
                if (!par_flag && !stp_bad) begin
                    p_data_q <= shift_q;
                end
            end
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = dv_q;
    assign bus.par_err    = pe_q;
    assign bus.stp_err    = se_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8-bit and a 5-bit receiver share
// clock, reset and configuration; each has its own serial line and queue.
module tb_uart_rx_param;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    uart_rx_param_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus8 ();
    uart_rx_param_if #(.DATA_WIDTH(5), .PRESCALE_W(6)) bus5 ();

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));
    uart_rx_param #(.DATA_WIDTH(5), .PRESCALE_W(6)) dut5 (.CLK(CLK), .RST(RST), .bus(bus5));

    typedef struct packed {
        logic [2:0] flags;   // {data_valid, par_err, stp_err}
        logic [8:0] word;    // P_DATA expected while the pulse is high
    } exp_t;

    exp_t       q8[$];
    exp_t       q5[$];
    logic [8:0] last_word[2];
    int         n_checks = 0;
    int         n_errors = 0;
    int         c_p;
    bit         c_pe;
    bit         c_pt;
    bit         c_s2;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int presc, input bit pe, input bit pt, input bit s2);
        bus8.Prescale = 6'(presc);
        bus5.Prescale = 6'(presc);
        bus8.PAR_EN   = pe;
        bus5.PAR_EN   = pe;
        bus8.PAR_TYP  = pt;
        bus5.PAR_TYP  = pt;
        bus8.STP_2    = s2;
        bus5.STP_2    = s2;
        c_p  = (presc < 4) ? 4 : presc;
        c_pe = pe;
        c_pt = pt;
        c_s2 = s2;
    endtask

    task automatic drive_line(input bit sel, input logic v);
        if (sel) bus5.RX_IN = v;
        else     bus8.RX_IN = v;
    endtask

    task automatic drive_bit(input bit sel, input logic v, input bit glitch);
        for (int j = 0; j < c_p; j++) begin
            @(negedge CLK);
            drive_line(sel, (glitch && j == c_p / 2) ? ~v : v);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [8:0] data, input logic par_bit,
                              input logic stop1, input logic stop2, input int glitch_bit,
                              input int gap, input int poke);
        int         dw;
        logic [8:0] word;
        logic       ep;
        bit         pe;
        bit         se;
        exp_t       e;
        dw   = sel ? 5 : 8;
        word = data & ((9'd1 << dw) - 9'd1);
        ep   = (^word) ^ c_pt;
        pe   = c_pe && (par_bit != ep);
        se   = !stop1 || (c_s2 && !stop2);
        e.flags = {~(pe | se), pe, se};
        e.word  = (pe | se) ? last_word[sel] : word;
        if (!(pe | se)) last_word[sel] = word;
        if (sel) q5.push_back(e);
        else     q8.push_back(e);

        drive_bit(sel, 1'b0, 1'b0);
        if (poke >= 0) begin
            bus8.Prescale = 6'(poke);
            bus5.Prescale = 6'(poke);
        end
        for (int i = 0; i < dw; i++) drive_bit(sel, word[i], glitch_bit == i);
        if (c_pe) drive_bit(sel, par_bit, 1'b0);
        drive_bit(sel, stop1, 1'b0);
        if (c_s2) drive_bit(sel, stop2, 1'b0);
        for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            drive_line(sel, 1'b1);
        end
    endtask

    task automatic wait_drain(input bit sel);
        repeat (2 * c_p + 6) @(negedge CLK);
        if (sel) begin
            check_val("drain5", q5.size(), 0);
            check_val("idle5", bus5.busy, 0);
        end else begin
            check_val("drain8", q8.size(), 0);
            check_val("idle8", bus8.busy, 0);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (bus8.data_valid || bus8.par_err || bus8.stp_err) begin
            if (q8.size() == 0) begin
                check_val("spur8", {bus8.data_valid, bus8.par_err, bus8.stp_err}, 3'b000);
            end else begin
                e = q8.pop_front();
                check_val("flags8", {bus8.data_valid, bus8.par_err, bus8.stp_err}, e.flags);
                check_val("word8", bus8.P_DATA, e.word);
            end
        end
        if (bus5.data_valid || bus5.par_err || bus5.stp_err) begin
            if (q5.size() == 0) begin
                check_val("spur5", {bus5.data_valid, bus5.par_err, bus5.stp_err}, 3'b000);
            end else begin
                e = q5.pop_front();
                check_val("flags5", {bus5.data_valid, bus5.par_err, bus5.stp_err}, e.flags);
                check_val("word5", bus5.P_DATA, e.word);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus8.RX_IN   = 1'b1;
        bus5.RX_IN   = 1'b1;
        last_word[0] = '0;
        last_word[1] = '0;
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rst_pdata8", bus8.P_DATA, 0);
        check_val("rst_dv8", bus8.data_valid, 0);
        check_val("rst_pe8", bus8.par_err, 0);
        check_val("rst_se8", bus8.stp_err, 0);
        check_val("rst_busy8", bus8.busy, 0);
        check_val("rst_pdata5", bus5.P_DATA, 0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        // P=8, no parity, one stop bit
        send_frame(0, 9'hA5, 1'b0, 1'b1, 1'b1, -1, 4, -1);
        wait_drain(0);
        // mid-frame Prescale change must be ignored
        send_frame(0, 9'h3C, 1'b0, 1'b1, 1'b1, -1, 4, 3);
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        wait_drain(0);
        // Prescale below 4 runs as 4
        set_cfg(2, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'hC3, 1'b0, 1'b1, 1'b1, -1, 4, -1);
        wait_drain(0);

        // even parity at P=16: good, then wrong parity bit
        set_cfg(16, 1'b1, 1'b0, 1'b0);
        send_frame(0, 9'h37, 1'b1, 1'b1, 1'b1, -1, 4, -1);
        send_frame(0, 9'h37, 1'b0, 1'b1, 1'b1, -1, 4, -1);
        wait_drain(0);

        // two stop bits at P=32: second stop low, then a clean frame
        set_cfg(32, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h5A, 1'b0, 1'b1, 1'b0, -1, 4, -1);
        send_frame(0, 9'h96, 1'b0, 1'b1, 1'b1, -1, 4, -1);
        wait_drain(0);

        // parity and stop errors in the same frame
        set_cfg(16, 1'b1, 1'b1, 1'b0);
        send_frame(0, 9'h01, 1'b1, 1'b0, 1'b1, -1, 4, -1);
        wait_drain(0);

        // 3-clock start glitch: back to IDLE silently
        set_cfg(16, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            drive_line(0, 1'b0);
        end
        @(negedge CLK);
        drive_line(0, 1'b1);
        @(negedge CLK);
        check_val("glitch_busy8", bus8.busy, 1);
        wait_drain(0);
        // one-cycle high glitch at the mid-sample of data bit 2
        send_frame(0, 9'h00, 1'b0, 1'b1, 1'b1, 2, 4, -1);
        wait_drain(0);

        // 5-bit receiver, odd parity, back-to-back frames with no gap
        set_cfg(8, 1'b1, 1'b1, 1'b0);
        send_frame(1, 9'h13, 1'b0, 1'b1, 1'b1, -1, 0, -1);
        send_frame(1, 9'h0C, 1'b1, 1'b1, 1'b1, -1, 6, -1);
        wait_drain(1);

        // reset in the middle of a DATA bit, then a clean frame
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        drive_bit(0, 1'b0, 1'b0);
        drive_bit(0, 1'b1, 1'b0);
        drive_bit(0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        drive_line(0, 1'b1);
        repeat (3) @(negedge CLK);
        check_val("abort_pdata8", bus8.P_DATA, 0);
        check_val("abort_busy8", bus8.busy, 0);
        last_word[0] = '0;
        last_word[1] = '0;
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        send_frame(0, 9'h81, 1'b0, 1'b1, 1'b1, -1, 4, -1);
        wait_drain(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
